// File: rtl/pc_stack_unit.sv
// ---------------------------------------------------------------------------
// pc_stack_unit
//
// Fetch program counter with an internal next-PC generator and a hardware
// return-address stack. The control FSM drives one-cycle request strobes;
// this block resolves them by fixed priority (ret > call > jump > branch >
// increment) and presents the resulting fetch address on pc_count.
//
// Parameters
//   WIDTH       PC width in bits; all PC arithmetic wraps modulo 2^WIDTH
//   INC_STEP    amount added to the PC on a plain sequential advance
//   RESET_VEC   PC value loaded by reset
//   DISP_W      width of the signed branch displacement (<= WIDTH)
//   STACK_DEPTH number of return-address entries (>= 2)
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset, overrides every request
//   pc_en        advance enable; low holds PC, stack and error flag
//   jump         absolute jump request, target jump_addr
//   jump_addr    absolute jump target
//   branch       taken-branch request, PC + sign-extended branch_disp
//   branch_disp  two's-complement branch displacement
//   call         push return address (PC + INC_STEP), go to call_addr
//   call_addr    call target
//   ret          pop the top return address into the PC
//   pc_count     current PC (registered)
//   pc_next      value pc_count takes at the next edge when pc_en = 1
//   stack_full   stack holds STACK_DEPTH entries (registered)
//   stack_empty  stack holds no entries (registered)
//   stack_err    sticky overflow/underflow flag, cleared only by rst
// ---------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int WIDTH       = 16,
    parameter int INC_STEP    = 1,
    parameter int RESET_VEC   = 0,
    parameter int DISP_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_en,
    input  logic              jump,
    input  logic [WIDTH-1:0]  jump_addr,
    input  logic              branch,
    input  logic [DISP_W-1:0] branch_disp,
    input  logic              call,
    input  logic [WIDTH-1:0]  call_addr,
    input  logic              ret,
    output logic [WIDTH-1:0]  pc_count,
    output logic [WIDTH-1:0]  pc_next,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    // Pointer counts 0..STACK_DEPTH inclusive, so it needs one more code
    // than the entry index does.
    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic [WIDTH-1:0] INC_VEC   = WIDTH'(INC_STEP);
    localparam logic [WIDTH-1:0] RST_VEC   = WIDTH'(RESET_VEC);
    localparam logic [PTR_W-1:0] PTR_FULL  = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // Resolved operation for this cycle after priority encoding.
    localparam logic [2:0] OP_INC    = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RET    = 3'd4;

    // State
    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic             err_q,   err_d;
    logic             full_q,  full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    // Combinational helpers
    logic [2:0]       op_s;
    logic             push_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic [WIDTH-1:0] disp_ext_s;
    logic [WIDTH-1:0] top_s;
    logic [IDX_W-1:0] top_idx_s;
    logic [IDX_W-1:0] push_idx_s;

    // Sign-extend the displacement; adding it modulo 2^WIDTH gives a
    // signed relative branch without any explicit subtraction path.
    assign disp_ext_s = WIDTH'($signed(branch_disp));
    assign ret_addr_s = pc_q + INC_VEC;

    // Index arithmetic is truncated to the entry-index width. Only the
    // non-empty case reads top and only the non-full case writes, so the
    // truncated values are always in range when they are used.
    assign top_idx_s  = IDX_W'(ptr_q - PTR_ONE);
    assign push_idx_s = IDX_W'(ptr_q);
    assign top_s      = stack_q[top_idx_s];

    // Priority encode the request strobes; lower-priority strobes are dropped.
    always_comb begin
        op_s = OP_INC;
        if (ret) begin
            op_s = OP_RET;
        end else if (call) begin
            op_s = OP_CALL;
        end else if (jump) begin
            op_s = OP_JUMP;
        end else if (branch) begin
            op_s = OP_BRANCH;
        end else begin
            op_s = OP_INC;
        end
    end

    // Next-state computation for PC, stack pointer and error flag.
    always_comb begin
        pc_d   = ret_addr_s;
        ptr_d  = ptr_q;
        err_d  = err_q;
        push_s = 1'b0;
        case (op_s)
            OP_RET: begin
                if (!empty_q) begin
                    pc_d  = top_s;
                    ptr_d = ptr_q - PTR_ONE;
                end else begin
                    // Underflow: fall through to a sequential advance.
                    pc_d  = ret_addr_s;
                    err_d = 1'b1;
                end
            end
            OP_CALL: begin
                // The call target is taken even when the push is refused.
                pc_d = call_addr;
                if (!full_q) begin
                    push_s = 1'b1;
                    ptr_d  = ptr_q + PTR_ONE;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_JUMP: begin
                pc_d = jump_addr;
            end
            OP_BRANCH: begin
                pc_d = pc_q + disp_ext_s;
            end
            OP_INC: begin
                pc_d = ret_addr_s;
            end
            default: begin
                pc_d = ret_addr_s;
            end
        endcase
    end

    // Status flags follow the pointer value that will be registered.
    always_comb begin
        full_d  = (ptr_d == PTR_FULL);
        empty_d = (ptr_d == PTR_ZERO);
    end

    // PC, pointer and status registers; stall holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RST_VEC;
            ptr_q   <= PTR_ZERO;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (pc_en) begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Return-address storage; contents need no reset because the pointer
    // alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && pc_en && push_s) begin
            stack_q[push_idx_s] <= ret_addr_s;
        end
    end

    assign pc_count    = pc_q;
    assign pc_next     = pc_d;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign stack_err   = err_q;

endmodule
